// File: rtl/serial_add_ctrl.sv
//------------------------------------------------------------------------------
// Module : serial_add_ctrl (with its full_adder cell)
// Brief  : Bit-serial add/subtract controller using a single 1-bit full adder,
//          LSB first, one bit per clock.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic sum,
  output logic carry
);
  assign sum   = x ^ y ^ z;
  assign carry = (x & y) | (z & (x ^ y));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cmsb_q, cmsb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_sum;
  logic fa_carry;
  logic load;

  full_adder u_fa (
    .x     (op_a_q[0]),
    .y     (op_b_q[0]),
    .z     (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // A new operation may be launched from IDLE or straight out of DONE.
  assign load = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cmsb_d  = cmsb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        busy    = 1'b1;
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish results here so they stay stable until the next op ends.
          cmsb_d  = carry_q;
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      op_a_d  = a;
      op_b_d  = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
      res_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cmsb_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cmsb_q  <= cmsb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = cout_q ^ cmsb_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_serial_add_ctrl
// Brief  : Self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=4).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 0, sub8 = 0, cin8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start4 = 0, sub4 = 0, cin4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] sum4;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    string      nm;
  } exp_t;

  typedef struct {
    string      nm;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  exp_t q8[$];
  exp_t q4[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic in plain integers, independent of any bit-serial view.
  function automatic exp_t model(input int w, input int av, input int bv,
                                 input bit s, input bit c, input string nm);
    exp_t e;
    int   mask, sa, sb, r;
    mask = (1 << w) - 1;
    sa   = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb   = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    r    = s ? sa - sb : sa + sb + int'(c);
    e.sum  = 8'((s ? av - bv : av + bv + int'(c)) & mask);
    e.cout = s ? (av >= bv) : ((av + bv + int'(c)) > mask);
    e.ovf  = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
    e.nm   = nm;
    return e;
  endfunction

  // Scoreboards: every done pulse pops and checks one expected result.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL w8_unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk({e.nm, ".sum"},  32'(sum8),  32'(e.sum));
        chk({e.nm, ".cout"}, 32'(cout8), 32'(e.cout));
        chk({e.nm, ".ovf"},  32'(ovf8),  32'(e.ovf));
      end
    end
    if (done4) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL w4_unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk({e.nm, ".sum"},  32'(sum4),  32'(e.sum));
        chk({e.nm, ".cout"}, 32'(cout4), 32'(e.cout));
        chk({e.nm, ".ovf"},  32'(ovf4),  32'(e.ovf));
      end
    end
  end

  task automatic do_op8(input vec_t v);
    exp_t e;
    int   cyc, bcnt;
    bit   seen;
    e = '{sum: v.sum, cout: v.cout, ovf: v.ovf, nm: v.nm};
    @(posedge clk); #1;
    sub8 = v.sub; a8 = v.a; b8 = v.b; cin8 = v.cin; start8 = 1'b1;
    q8.push_back(e);
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = ~v.sub; cin8 = ~v.cin;
    cyc = 0; bcnt = 0; seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (busy8) bcnt++;
      if (done8) begin seen = 1; cyc = k; end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s.timeout actual=no_done required=done", v.nm);
    end else begin
      chk({v.nm, ".latency"}, 32'(cyc), 32'd9);
      chk({v.nm, ".busy_cycles"}, 32'(bcnt), 32'd8);
      @(negedge clk);
      chk({v.nm, ".hold_sum"}, 32'(sum8), 32'(v.sum));
      chk({v.nm, ".done_once"}, 32'(done8), 32'd0);
    end
  endtask

  task automatic do_op4(input int av, input int bv, input bit s, input bit c);
    bit seen;
    @(posedge clk); #1;
    a4 = 4'(av); b4 = 4'(bv); sub4 = s; cin4 = c; start4 = 1'b1;
    q4.push_back(model(4, av, bv, s, c, $sformatf("w4_%0h_%0h_s%0d_c%0d", av, bv, s, c)));
    @(posedge clk); #1;
    start4 = 1'b0;
    seen = 0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (done4) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL w4_timeout actual=no_done required=done");
    end
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{"add_5a_3c",   1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vt[1] = '{"add_ff_01",   1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{"add_00_00_c", 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[3] = '{"sub_10_20",   1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
    vt[4] = '{"sub_10_20_c", 1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vt[5] = '{"sub_80_01",   1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vt[6] = '{"sub_80_01_c", 1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[7] = '{"add_7f_7f_c", 1'b0, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    vt[8] = '{"sub_00_00",   1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy8), 0);
    chk("rst.done", 32'(done8), 0);
    chk("rst.sum",  32'(sum8),  0);
    chk("rst.cout", 32'(cout8), 0);
    chk("rst.ovf",  32'(ovf8),  0);
    rst_n = 1'b1;

    foreach (vt[i]) do_op8(vt[i]);

    // Start pulse and operand churn mid-run must be ignored.
    begin
      int dcnt = 0;
      @(posedge clk); #1;
      sub8 = 0; a8 = 8'h5A; b8 = 8'h3C; cin8 = 0; start8 = 1;
      q8.push_back(model(8, 'h5A, 'h3C, 0, 0, "ignore_start"));
      @(posedge clk); #1; start8 = 0;
      for (int k = 1; k <= 25; k++) begin
        @(negedge clk);
        if (done8) dcnt++;
        if (k == 3) begin a8 = 8'h01; b8 = 8'hF0; sub8 = 1; cin8 = 1; start8 = 1; end
        if (k == 4) start8 = 0;
      end
      chk("ignore_start.done_count", 32'(dcnt), 1);
    end

    // start held through DONE launches the next op with no idle cycle.
    begin
      int t1 = 0, t2 = 0;
      @(posedge clk); #1;
      sub8 = 0; a8 = 8'h12; b8 = 8'h34; cin8 = 0; start8 = 1;
      q8.push_back(model(8, 'h12, 'h34, 0, 0, "b2b_first"));
      @(posedge clk); #1;
      sub8 = 1; a8 = 8'h50; b8 = 8'h70; cin8 = 1;
      q8.push_back(model(8, 'h50, 'h70, 1, 1, "b2b_second"));
      for (int k = 1; k <= 30 && t2 == 0; k++) begin
        @(negedge clk);
        if (done8) begin
          if (t1 == 0) t1 = k; else t2 = k;
        end
        if (k == 10) chk("b2b.busy_no_idle", 32'(busy8), 1);
        if (t1 != 0 && k == t1) begin @(posedge clk); #1; start8 = 0; end
      end
      chk("b2b.first_latency", 32'(t1), 9);
      chk("b2b.gap", 32'(t2 - t1), 9);
    end

    // Asynchronous reset at RUN bit 4 aborts the op.
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    sub8 = 0; a8 = 8'h33; b8 = 8'h44; cin8 = 0; start8 = 1;
    @(posedge clk); #1; start8 = 0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst.sum",  32'(sum8),  0);
    chk("midrun_rst.cout", 32'(cout8), 0);
    chk("midrun_rst.ovf",  32'(ovf8),  0);
    chk("midrun_rst.busy", 32'(busy8), 0);
    chk("midrun_rst.done", 32'(done8), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrun_rst.idle_busy", 32'(busy8), 0);
    do_op8('{"after_rst_01_01", 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0});

    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int av = 0; av < 16; av++)
          for (int bv = 0; bv < 16; bv++)
            do_op4(av, bv, bit'(s), bit'(c));

    repeat (4) @(negedge clk);
    chk("w8_scoreboard_empty", 32'(q8.size()), 0);
    chk("w4_scoreboard_empty", 32'(q4.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
